// File: rtl/waterbear_core.sv
// Multi-cycle accumulator CPU: fetch/decode/execute/writeback FSM, internal data memory.
// Optional WATERBEAR_TRACE_EN adds a retire trace port (trace_valid/trace_pc/trace_ir).
module waterbear_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              retire
`ifdef WATERBEAR_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [15:0]       trace_ir
`endif
);

  localparam int unsigned AW = $clog2(DMEM_DEPTH);

  localparam logic [3:0] OP_LDR = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_EQU = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_HLT = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_ir;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_src;
  logic [3:0]          r_opc;
  logic [AW-1:0]       r_addr;
  logic                r_z;
  logic                r_c;
  logic                r_retire;
  logic [DATA_W-1:0]   r_dmem [DMEM_DEPTH];
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic                w_unused_rsvd;

  assign w_sum         = {1'b0, r_acc} + {1'b0, r_src};
  assign w_diff        = {1'b0, r_acc} - {1'b0, r_src};
  assign w_unused_rsvd = ^r_ir[10:8];

  // rst also masks the request so no fetch is advertised while reset is held
  assign imem_req   = (r_state == S_FETCH) && !rst;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign acc        = r_acc;
  assign zero_flag  = r_z;
  assign carry_flag = r_c;
  assign halted     = (r_state == S_HALT);
  assign retire     = r_retire;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (imem_valid) w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = (r_opc == OP_HLT) ? S_HALT : S_WRITEBACK;
      S_WRITEBACK: w_next = S_FETCH;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir     <= '0;
      r_pc     <= '0;
      r_acc    <= '0;
      r_src    <= '0;
      r_opc    <= '0;
      r_addr   <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      // EXECUTE always leads to WRITEBACK or HALT entry, both of which retire
      r_retire <= (r_state == S_EXECUTE);
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_DECODE: begin
          r_opc  <= r_ir[15:12];
          r_addr <= r_ir[AW-1:0];
          r_src  <= r_ir[11] ? DATA_W'(r_ir[7:0]) : r_dmem[r_ir[AW-1:0]];
        end
        S_EXECUTE: begin
          case (r_opc)
            OP_LDR: begin
              r_acc <= r_src;
              r_z   <= (r_src == '0);
            end
            OP_ADD: begin
              {r_c, r_acc} <= w_sum;
              r_z          <= (w_sum[DATA_W-1:0] == '0);
            end
            OP_SUB: begin
              r_acc <= w_diff[DATA_W-1:0];
              r_c   <= w_diff[DATA_W];
              r_z   <= (w_diff[DATA_W-1:0] == '0);
            end
            OP_EQU: r_z <= (r_acc == r_src);
            OP_JMP: r_pc <= r_src[PC_W-1:0];
            OP_JZ:  if (r_z) r_pc <= r_src[PC_W-1:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_EXECUTE) && (r_opc == OP_STR)) r_dmem[r_addr] <= r_acc;
  end

`ifdef WATERBEAR_TRACE_EN
  logic [PC_W-1:0] r_fetch_pc;
  logic            r_trace_valid;
  logic [PC_W-1:0] r_trace_pc;
  logic [15:0]     r_trace_ir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= '0;
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_ir    <= '0;
    end else begin
      r_trace_valid <= (r_state == S_EXECUTE);
      if ((r_state == S_FETCH) && imem_valid) r_fetch_pc <= r_pc;
      if (r_state == S_EXECUTE) begin
        r_trace_pc <= r_fetch_pc;
        r_trace_ir <= r_ir;
      end
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_ir    = r_trace_ir;
`endif

endmodule

// File: tb/tb_waterbear_core.sv
// Bench for waterbear_core: directed programs plus random programs against an ISA-level model.
`timescale 1ns/1ps
module tb_waterbear_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr, pc, acc;
  logic [15:0] imem_rdata;
  logic        zero_flag, carry_flag, halted, retire;

  logic        req2, valid2, z2, c2, h2, ret2;
  logic [3:0]  addr2, pc2;
  logic [7:0]  acc2;
  logic [15:0] rdata2;

`ifdef WATERBEAR_TRACE_EN
  logic        tv, tv2;
  logic [7:0]  tpc;
  logic [3:0]  tpc2;
  logic [15:0] tir, tir2;
`endif

  waterbear_core #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc), .acc(acc),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted), .retire(retire)
`ifdef WATERBEAR_TRACE_EN
    , .trace_valid(tv), .trace_pc(tpc), .trace_ir(tir)
`endif
  );

  waterbear_core #(.DATA_W(8), .PC_W(4), .DMEM_DEPTH(64)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_valid(valid2), .pc(pc2), .acc(acc2),
    .zero_flag(z2), .carry_flag(c2), .halted(h2), .retire(ret2)
`ifdef WATERBEAR_TRACE_EN
    , .trace_valid(tv2), .trace_pc(tpc2), .trace_ir(tir2)
`endif
  );

  int          ncomp = 0;
  int          nfail = 0;
  logic [15:0] prog  [256];
  logic [15:0] prog2 [16];
  bit          manual = 1'b0;
  bit          lat_rand = 1'b0;
  int          lat_fixed = 0;
  bit          man_valid = 1'b0;
  logic [15:0] man_rdata = '0;
  int          lat_hist [512];

  // reference model state
  int          macc, mz, mc, mpc, mhalt;
  int          mdm [64];
  int          g_halt_cyc, g_nret, g_req;
  logic [7:0]  rec_acc [64];
  bit          rec_c [64];
  bit          rec_z [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // instruction memory for dut: per-fetch latency, recorded per fetch index
  initial begin
    bit need_new;
    int wcnt, cur_lat, fidx;
    need_new = 1'b1; wcnt = 0; cur_lat = 0; fidx = 0;
    imem_valid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        need_new = 1'b1;
        fidx = 0;
      end
      if (manual) begin
        imem_valid = man_valid;
        imem_rdata = man_rdata;
      end else if (rst || !imem_req) begin
        imem_valid = 1'b0;
        imem_rdata = 16'($urandom);
      end else begin
        if (need_new) begin
          cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
          if (fidx < 512) lat_hist[fidx] = cur_lat;
          fidx++;
          need_new = 1'b0;
          wcnt = 0;
        end
        if (wcnt == cur_lat) begin
          imem_valid = 1'b1;
          imem_rdata = prog[imem_addr];
          need_new   = 1'b1;
        end else begin
          imem_valid = 1'b0;
          imem_rdata = 16'($urandom);
          wcnt++;
        end
      end
    end
  end

  initial begin
    valid2 = 1'b0; rdata2 = '0;
    forever begin
      @(negedge clk);
      valid2 = req2;
      rdata2 = prog2[addr2];
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    logic [15:0] w;
    int op, opd, src;
    w   = prog[mpc];
    op  = int'(w[15:12]);
    opd = int'(w[7:0]);
    src = w[11] ? opd : mdm[opd % 64];
    mpc = (mpc + 1) % 256;
    case (op)
      1: begin macc = src; mz = (macc == 0); end
      2: mdm[opd % 64] = macc;
      3: begin macc = macc + src; mc = (macc > 255); macc = macc % 256; mz = (macc == 0); end
      4: begin mc = (src > macc); macc = (macc - src + 256) % 256; mz = (macc == 0); end
      5: mz = (macc == src);
      6: mpc = src % 256;
      7: mhalt = 1;
      8: if (mz != 0) mpc = src % 256;
      default: ;
    endcase
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (chk) begin
      check("rst_pc", pc, 0);
      check("rst_acc", acc, 0);
      check("rst_z", zero_flag, 0);
      check("rst_c", carry_flag, 0);
      check("rst_req", imem_req, 0);
      check("rst_halted", halted, 0);
      check("rst_retire", retire, 0);
    end
    macc = 0; mz = 0; mc = 0; mpc = 0; mhalt = 0;
    rst = 1'b0;
  endtask

  task automatic run(input int budget);
    int cyc, last;
    bit done;
    cyc = 0; last = 0; done = 1'b0;
    g_halt_cyc = -1; g_nret = 0; g_req = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (imem_req) g_req++;
      if (retire) begin
        check("instr_cycles", cyc - last, 4 + lat_hist[g_nret % 512]);
        last = cyc;
        model_step();
        check("acc", acc, macc);
        check("zero", zero_flag, mz);
        check("carry", carry_flag, mc);
        check("pc", pc, mpc);
        check("halted", halted, mhalt);
        if (g_nret < 64) begin
          rec_acc[g_nret] = acc;
          rec_c[g_nret]   = carry_flag;
          rec_z[g_nret]   = zero_flag;
        end
        g_nret++;
      end
      if (halted && g_halt_cyc < 0) g_halt_cyc = cyc;
      if (g_halt_cyc >= 0 && cyc >= g_halt_cyc + 3) done = 1'b1;
    end
    check("halt_reached", g_halt_cyc >= 0, 1);
  endtask

  task automatic load_sum();
    foreach (prog[i]) prog[i] = 16'h7000;
    prog[0] = 16'h1805; prog[1] = 16'h200D; prog[2] = 16'h1807; prog[3] = 16'h200E;
    prog[4] = 16'h100D; prog[5] = 16'h300E; prog[6] = 16'h200F; prog[7] = 16'h7000;
  endtask

  initial begin
    int nr;
    int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 12, 15};
    foreach (prog2[i]) prog2[i] = 16'h0000;
    prog2[0] = 16'h680F;

    // x = 5 + 7, zero-wait
    load_sum();
    lat_rand = 1'b0; lat_fixed = 0;
    do_reset(1'b1);
    run(200);
    check("sum_halt_cycle", g_halt_cyc, 32);
    check("sum_retires", g_nret, 8);
    check("sum_acc", acc, 12);
    check("sum_c", carry_flag, 0);
    check("sum_z", zero_flag, 0);
    check("sum_pc", pc, 8);
    check("sum_dmem15", dut.r_dmem[15], 12);

    // same program, 3 wait cycles per fetch
    lat_fixed = 3;
    do_reset(1'b0);
    run(400);
    check("slow_halt_cycle", g_halt_cyc, 56);
    check("slow_req_cycles", g_req, 32);
    check("slow_retires", g_nret, 8);
    check("slow_acc", acc, 12);
    check("slow_dmem15", dut.r_dmem[15], 12);

    // borrow then carry into zero
    foreach (prog[i]) prog[i] = 16'h7000;
    prog[0] = 16'h1803; prog[1] = 16'h4805; prog[2] = 16'h3802;
    lat_fixed = 0;
    do_reset(1'b0);
    run(100);
    check("sub_acc", rec_acc[1], 254);
    check("sub_c", rec_c[1], 1);
    check("sub_z", rec_z[1], 0);
    check("add_acc", acc, 0);
    check("add_c", carry_flag, 1);
    check("add_z", zero_flag, 1);

    // countdown loop
    foreach (prog[i]) prog[i] = 16'h7000;
    prog[0] = 16'h1803; prog[1] = 16'h4801; prog[2] = 16'h5800;
    prog[3] = 16'h8806; prog[4] = 16'h6801; prog[5] = 16'h0000; prog[6] = 16'h7000;
    do_reset(1'b0);
    run(200);
    check("loop_retires", g_nret, 13);
    check("loop_acc", acc, 0);
    check("loop_pc", pc, 7);
    check("loop_halted", halted, 1);

    // reset mid-fetch, late response while reset still held
    manual = 1'b1; man_valid = 1'b0;
    do_reset(1'b0);
    @(negedge clk);
    check("mf_req", imem_req, 1);
    check("mf_addr", imem_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 man_valid = 1'b1; man_rdata = 16'h18AA;
    @(negedge clk);
    check("mf_rst_pc", pc, 0);
    check("mf_rst_retire", retire, 0);
    @(posedge clk); #1 rst = 1'b0; man_valid = 1'b0;
    nr = 0;
    repeat (6) begin
      @(negedge clk);
      if (retire) nr++;
    end
    check("mf_no_retire", nr, 0);
    check("mf_pc", pc, 0);
    check("mf_acc", acc, 0);
    check("mf_restart_addr", imem_addr, 0);
    check("mf_restart_req", imem_req, 1);
    @(posedge clk); #1 man_valid = 1'b1; man_rdata = 16'h1855;
    @(posedge clk); #1 man_valid = 1'b0;
    nr = 0;
    while (!retire && nr < 10) begin
      @(negedge clk);
      nr++;
    end
    check("mf_retired", retire, 1);
    check("mf_new_acc", acc, 8'h55);
    check("mf_new_pc", pc, 1);
    manual = 1'b0;

    // 4-bit pc wrap on the second core
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    check("wrap_fetch15", addr2, 15);
    check("wrap_req15", req2, 1);
    @(negedge clk);
    check("wrap_pc_after15", pc2, 0);
    repeat (3) @(negedge clk);
    check("wrap_fetch0", addr2, 0);
    check("wrap_req0", req2, 1);

    // random programs with random fetch latency
    lat_rand = 1'b1;
    for (int p = 0; p < 5; p++) begin
      foreach (prog[i]) prog[i] = 16'h7000;
      for (int a = 0; a < 8; a++) begin
        prog[2*a]   = {4'h1, 1'b1, 3'b000, 8'($urandom)};
        prog[2*a+1] = {4'h2, 1'($urandom), 3'($urandom), 8'(a)};
      end
      for (int i = 16; i < 36; i++) begin
        int op;
        logic imm;
        logic [7:0] opd;
        op = ops[$urandom_range(0, 10)];
        if (op == 6 || op == 8) begin
          imm = 1'b1;
          opd = 8'($urandom_range(i + 1, 36));
        end else begin
          imm = 1'($urandom);
          opd = (imm && op != 2) ? 8'($urandom) : 8'($urandom_range(0, 7));
        end
        prog[i] = {4'(op), imm, 3'($urandom), opd};
      end
      prog[36] = 16'h7000;
      do_reset(1'b0);
      run(2000);
      for (int a = 0; a < 8; a++) check("rand_dmem", dut.r_dmem[a], mdm[a]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
